// File: rtl/ex_operand_stage_if.sv
// Decode-to-execute operand bus: ID-stage fields, bypass candidates from MEM/WB,
// and the forwarded operands and registered control returned by the EX stage.
interface ex_operand_stage_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [31:0] id_rf_rd1;
  logic [31:0] id_rf_rd2;
  logic [31:0] id_imm;
  logic [3:0]  id_alu_ctrl;
  logic        id_src1_sel;
  logic        id_src2_sel;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        flush;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic [31:0] mem_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_result;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [3:0]  alu_ctrl;
  logic        ex_valid;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic [31:0] ex_rs2_data;
  logic        id_stall;

  // Pipeline side: drives decode fields and bypass candidates.
  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rf_rd1, id_rf_rd2, id_imm,
           id_alu_ctrl, id_src1_sel, id_src2_sel, id_reg_write, id_mem_read, flush,
           mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
    input  operand1, operand2, alu_ctrl, ex_valid, ex_reg_write, ex_mem_read, ex_rd,
           ex_rs2_data, id_stall
  );

  // EX operand stage side.
  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rf_rd1, id_rf_rd2, id_imm,
           id_alu_ctrl, id_src1_sel, id_src2_sel, id_reg_write, id_mem_read, flush,
           mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
    output operand1, operand2, alu_ctrl, ex_valid, ex_reg_write, ex_mem_read, ex_rd,
           ex_rs2_data, id_stall
  );
endinterface

// File: rtl/ex_operand_stage.sv
// EX operand stage: ID/EX pipeline register, load-use hazard detection and
// MEM/WB operand forwarding into the ALU operand muxes.
module ex_operand_stage (
  input logic               clk,
  input logic               rst_n,
  ex_operand_stage_if.slave bus
);

  logic        ex_valid_q;
  logic [31:0] pc_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [4:0]  rd_q;
  logic [31:0] rf_rd1_q;
  logic [31:0] rf_rd2_q;
  logic [31:0] imm_q;
  logic [3:0]  alu_ctrl_q;
  logic        src1_sel_q;
  logic        src2_sel_q;
  logic        reg_write_q;
  logic        mem_read_q;

  logic        stall;
  logic [31:0] fwd_rs1;
  logic [31:0] fwd_rs2;

  // Load-use hazard: a valid load in EX targets a register the ID instruction reads.
  always_comb begin
    stall = 1'b0;
    if (ex_valid_q && mem_read_q && (rd_q != 5'd0) && bus.id_valid) begin
      stall = ((rd_q == bus.id_rs1) && !bus.id_src1_sel) || (rd_q == bus.id_rs2);
    end
  end

  // Pipeline register: flush beats stall beats load; data fields hold on a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      pc_q        <= 32'd0;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      rd_q        <= 5'd0;
      rf_rd1_q    <= 32'd0;
      rf_rd2_q    <= 32'd0;
      imm_q       <= 32'd0;
      alu_ctrl_q  <= 4'd0;
      src1_sel_q  <= 1'b0;
      src2_sel_q  <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else if (bus.flush || stall) begin
      ex_valid_q  <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      ex_valid_q  <= bus.id_valid;
      pc_q        <= bus.id_pc;
      rs1_q       <= bus.id_rs1;
      rs2_q       <= bus.id_rs2;
      rd_q        <= bus.id_rd;
      rf_rd1_q    <= bus.id_rf_rd1;
      rf_rd2_q    <= bus.id_rf_rd2;
      imm_q       <= bus.id_imm;
      alu_ctrl_q  <= bus.id_alu_ctrl;
      src1_sel_q  <= bus.id_src1_sel;
      src2_sel_q  <= bus.id_src2_sel;
      reg_write_q <= bus.id_reg_write & bus.id_valid;
      mem_read_q  <= bus.id_mem_read & bus.id_valid;
    end
  end

  // Bypass: MEM is younger than WB so it wins; x0 is never forwarded.
  always_comb begin
    fwd_rs1 = rf_rd1_q;
    if (bus.mem_reg_write && (bus.mem_rd != 5'd0) && (bus.mem_rd == rs1_q)) begin
      fwd_rs1 = bus.mem_result;
    end else if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs1_q)) begin
      fwd_rs1 = bus.wb_result;
    end
    fwd_rs2 = rf_rd2_q;
    if (bus.mem_reg_write && (bus.mem_rd != 5'd0) && (bus.mem_rd == rs2_q)) begin
      fwd_rs2 = bus.mem_result;
    end else if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs2_q)) begin
      fwd_rs2 = bus.wb_result;
    end
  end

  // Operand muxes and registered control outputs.
  always_comb begin
    bus.operand1     = src1_sel_q ? pc_q : fwd_rs1;
    bus.operand2     = src2_sel_q ? imm_q : fwd_rs2;
    bus.ex_rs2_data  = fwd_rs2;
    bus.alu_ctrl     = alu_ctrl_q;
    bus.ex_valid     = ex_valid_q;
    bus.ex_reg_write = reg_write_q;
    bus.ex_mem_read  = mem_read_q;
    bus.ex_rd        = rd_q;
    bus.id_stall     = stall;
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed hazard/forwarding cases
// followed by randomized traffic against a behavioural model of the EX slot.
module tb_ex_operand_stage;

  logic clk;
  logic rst_n;

  ex_operand_stage_if bus ();

  ex_operand_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural view of what currently sits in the EX slot.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        s1;
    logic        s2;
    logic        rw;
    logic        mr;
    logic        known;  // data fields are defined (last edge loaded or reset)
  } ex_t;

  ex_t m;
  int  n_vec = 0;
  int  n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return rf;
    if (bus.mem_reg_write && bus.mem_rd == idx) return bus.mem_result;
    if (bus.wb_reg_write && bus.wb_rd == idx) return bus.wb_result;
    return rf;
  endfunction

  function automatic logic model_stall();
    logic hit;
    hit = (bus.id_rs2 == m.rd) || (!bus.id_src1_sel && bus.id_rs1 == m.rd);
    return m.valid && m.mr && (m.rd != 5'd0) && bus.id_valid && hit;
  endfunction

  task automatic model_reset();
    m = '0;
    m.known = 1'b1;
  endtask

  task automatic check_all();
    check("ex_valid", 32'(bus.ex_valid), 32'(m.valid));
    check("ex_reg_write", 32'(bus.ex_reg_write), 32'(m.rw));
    check("ex_mem_read", 32'(bus.ex_mem_read), 32'(m.mr));
    check("id_stall", 32'(bus.id_stall), 32'(model_stall()));
    if (m.known) begin
      check("operand1", bus.operand1, m.s1 ? m.pc : fwd(m.rs1, m.rd1));
      check("operand2", bus.operand2, m.s2 ? m.imm : fwd(m.rs2, m.rd2));
      check("ex_rs2_data", bus.ex_rs2_data, fwd(m.rs2, m.rd2));
      check("alu_ctrl", 32'(bus.alu_ctrl), 32'(m.alu));
      check("ex_rd", 32'(bus.ex_rd), 32'(m.rd));
    end
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    logic st;
    st = model_stall();
    @(posedge clk);
    if (rst_n) begin
      if (bus.flush || st) begin
        m.valid = 1'b0;
        m.rw    = 1'b0;
        m.mr    = 1'b0;
        m.known = 1'b0;
      end else begin
        m.valid = bus.id_valid;
        m.pc    = bus.id_pc;
        m.rs1   = bus.id_rs1;
        m.rs2   = bus.id_rs2;
        m.rd    = bus.id_rd;
        m.rd1   = bus.id_rf_rd1;
        m.rd2   = bus.id_rf_rd2;
        m.imm   = bus.id_imm;
        m.alu   = bus.id_alu_ctrl;
        m.s1    = bus.id_src1_sel;
        m.s2    = bus.id_src2_sel;
        m.rw    = bus.id_reg_write & bus.id_valid;
        m.mr    = bus.id_mem_read & bus.id_valid;
        m.known = 1'b1;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_pc = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
    bus.id_rf_rd1 = 0; bus.id_rf_rd2 = 0; bus.id_imm = 0; bus.id_alu_ctrl = 0;
    bus.id_src1_sel = 0; bus.id_src2_sel = 0; bus.id_reg_write = 0; bus.id_mem_read = 0;
    bus.flush = 0; bus.mem_rd = 0; bus.mem_reg_write = 0; bus.mem_result = 0;
    bus.wb_rd = 0; bus.wb_reg_write = 0; bus.wb_result = 0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_valid", 32'(bus.ex_valid), 32'd0);
    check_all();
    #1 rst_n = 1'b1;
  endtask

  task automatic load_x3();
    clear_inputs();
    bus.id_valid = 1; bus.id_rd = 5'd3; bus.id_reg_write = 1; bus.id_mem_read = 1;
    bus.id_rs1 = 5'd4; bus.id_alu_ctrl = 4'd0; bus.id_imm = 32'h10;
    tick();
  endtask

  task automatic dependent_on_x3();
    clear_inputs();
    bus.id_valid = 1; bus.id_rs1 = 5'd5; bus.id_rs2 = 5'd3; bus.id_rd = 5'd6;
    bus.id_rf_rd1 = 32'h11; bus.id_rf_rd2 = 32'h22; bus.id_reg_write = 1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #2;
    check_all();
    tick();
    tick();
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("post_rst_stall", 32'(bus.id_stall), 32'd0);

    // Basic ADD, no hazards.
    clear_inputs();
    bus.id_valid = 1; bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd2; bus.id_rd = 5'd4;
    bus.id_rf_rd1 = 32'd5; bus.id_rf_rd2 = 32'd7; bus.id_reg_write = 1;
    tick();
    clear_inputs();
    #1;
    check("add_op1", bus.operand1, 32'd5);
    check("add_op2", bus.operand2, 32'd7);
    check("add_valid", 32'(bus.ex_valid), 32'd1);
    check_all();

    // Double forward: MEM beats WB, WB used when MEM not writing.
    bus.mem_rd = 5'd1; bus.wb_rd = 5'd1; bus.mem_result = 32'hAA; bus.wb_result = 32'hBB;
    bus.mem_reg_write = 1; bus.wb_reg_write = 1;
    #1 check("fwd_mem", bus.operand1, 32'hAA);
    bus.mem_reg_write = 0;
    #1 check("fwd_wb", bus.operand1, 32'hBB);

    // x0 never forwarded.
    clear_inputs();
    bus.id_valid = 1; bus.id_rs1 = 5'd0; bus.id_rf_rd1 = 32'd0;
    tick();
    bus.id_valid = 0; bus.mem_rd = 5'd0; bus.mem_reg_write = 1; bus.mem_result = 32'h55;
    #1 check("x0_op1", bus.operand1, 32'd0);

    // Load-use: one bubble then the dependent instruction enters EX.
    load_x3();
    dependent_on_x3();
    #1 check("lu_stall", 32'(bus.id_stall), 32'd1);
    tick();
    check("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
    check("lu_bubble_stall", 32'(bus.id_stall), 32'd0);
    tick();
    check("lu_dep_valid", 32'(bus.ex_valid), 32'd1);
    check("lu_dep_rd", 32'(bus.ex_rd), 32'd6);

    // Flush together with stall: bubble and nothing captured.
    load_x3();
    dependent_on_x3();
    bus.flush = 1;
    tick();
    check("fs_valid", 32'(bus.ex_valid), 32'd0);
    check("fs_rd_held", 32'(bus.ex_rd), 32'd3);

    // Reset during a stall cancels the bubble; capture resumes after release.
    load_x3();
    dependent_on_x3();
    #1 check("rs_stall", 32'(bus.id_stall), 32'd1);
    reset_pulse();
    check("rs_stall_cleared", 32'(bus.id_stall), 32'd0);
    tick();
    check("rs_capture", 32'(bus.ex_valid), 32'd1);
    check_all();

    // Randomized traffic over a small register window to provoke hazards.
    repeat (400) begin
      bus.id_valid      = ($urandom_range(0, 3) != 0);
      bus.id_pc         = $urandom;
      bus.id_rs1        = 5'($urandom_range(0, 3));
      bus.id_rs2        = 5'($urandom_range(0, 3));
      bus.id_rd         = 5'($urandom_range(0, 3));
      bus.id_rf_rd1     = $urandom;
      bus.id_rf_rd2     = $urandom;
      bus.id_imm        = $urandom;
      bus.id_alu_ctrl   = 4'($urandom);
      bus.id_src1_sel   = 1'($urandom);
      bus.id_src2_sel   = 1'($urandom);
      bus.id_reg_write  = 1'($urandom);
      bus.id_mem_read   = ($urandom_range(0, 4) < 2);
      bus.flush         = ($urandom_range(0, 9) == 0);
      bus.mem_rd        = 5'($urandom_range(0, 3));
      bus.mem_reg_write = 1'($urandom);
      bus.mem_result    = $urandom;
      bus.wb_rd         = 5'($urandom_range(0, 3));
      bus.wb_reg_write  = 1'($urandom);
      bus.wb_result     = $urandom;
      #1 check_all();
      if ($urandom_range(0, 49) == 0) reset_pulse();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single pipeline clock; all state updates on its rising edge
  rst_n  in  1  asynchronous, active-low reset
  id_valid  in  1  decode stage holds a real instruction
  id_pc  in  32  decode-stage PC
  id_rs1, id_rs2, id_rd  in  5 each  source and destination register indices
  id_rf_rd1, id_rf_rd2  in  32 each  register-file read data
  id_imm  in  32  decoded immediate
  id_alu_ctrl  in  4  ALU opcode, in the codebase's ALU encoding
  id_src1_sel  in  1  0 = rs1 data, 1 = PC
  id_src2_sel  in  1  0 = rs2 data, 1 = immediate
  id_reg_write, id_mem_read  in  1 each  decode control bits
  flush  in  1  kill the instruction entering EX
  mem_rd  in  5; mem_reg_write  in  1; mem_result  in  32  MEM-stage writeback candidate
  wb_rd  in  5; wb_reg_write  in  1; wb_result  in  32  WB-stage writeback candidate
  operand1, operand2  out  32 each  forwarded ALU operands, combinational from EX registers
  alu_ctrl  out  4  registered opcode
  ex_valid, ex_reg_write, ex_mem_read  out  1 each  registered control, qualified by valid
  ex_rd  out  5  registered destination index
  ex_rs2_data  out  32  forwarded rs2 value, used as store data
  id_stall  out  1  combinational hold request to IF/ID

Function
REQ-002 EX registers SHALL hold: valid, pc, rs1, rs2, rd, rf_rd1, rf_rd2, imm, alu_ctrl, src sels, reg_write, mem_read.
REQ-003 Load-use: id_stall SHALL be 1 when all of the following hold: ex_valid=1; ex_mem_read=1; ex_rd!=0; id_valid=1; and ex_rd equals id_rs1 (with id_src1_sel=0) or id_rs2 (any sel).
REQ-004 On a rising edge with flush=1, the EX valid, reg_write and mem_read registers SHALL clear to 0; other fields are don't-care.
REQ-005 On a rising edge with flush=0 and id_stall=1, the stage SHALL insert a bubble: valid, reg_write and mem_read clear to 0.
REQ-006 Otherwise, the EX registers SHALL load all id_* fields; valid loads id_valid; reg_write and mem_read load their id_* bit ANDed with id_valid.
REQ-007 Precedence SHALL be: flush over stall over load. Latency from id_* to outputs SHALL be exactly 1 cycle.
REQ-008 Forwarded rs1 value SHALL be selected in priority order:
  (1) mem_result, if mem_reg_write=1, mem_rd!=0 and mem_rd equals rs1;
  (2) wb_result, if wb_reg_write=1, wb_rd!=0 and wb_rd equals rs1;
  (3) otherwise the registered rf_rd1.
  The rs2 value SHALL be forwarded identically.
REQ-009 Register x0 SHALL never be forwarded; index 0 always yields the registered rf data.
REQ-010 operand1 SHALL be the registered pc if src1_sel=1, else the forwarded rs1 value.
REQ-011 operand2 SHALL be the registered imm if src2_sel=1, else the forwarded rs2 value.
REQ-012 ex_rs2_data SHALL always be the forwarded rs2 value, regardless of src2_sel.
REQ-013 Forwarding SHALL apply even when ex_valid=0; downstream qualifies with ex_valid.
REQ-014 ex_reg_write and ex_mem_read SHALL never be 1 while ex_valid=0.

Reset
REQ-015 While rst_n=0, the following SHALL be 0 immediately, without waiting for a clock edge: ex_valid, ex_reg_write, ex_mem_read, ex_rd, alu_ctrl, and all stored data registers.
REQ-016 After rst_n deasserts, id_stall SHALL be 0 until a valid load occupies EX.
REQ-017 Reset asserted mid-stall SHALL clear the pending bubble; capture resumes at the first rising edge after release.

Verification
REQ-018 Basic ADD: id rs1=1, rs2=2, rf data 5 and 7, sels 0, no hazards -> next cycle operand1=5, operand2=7, ex_valid=1.
REQ-019 Double forward: mem_rd=wb_rd=1, mem_result=0xAA, wb_result=0xBB, both write enables 1 -> operand1=0xAA; with mem_reg_write=0 -> 0xBB.
REQ-020 x0 rule: mem_rd=0, mem_reg_write=1, rs1=0, rf_rd1=0 -> operand1=0.
REQ-021 Load-use: a load to x3 in EX and id_rs2=3 -> id_stall=1 for one cycle; next EX has ex_valid=0; the following cycle the dependent instruction loads.
REQ-022 Flush and stall together -> ex_valid=0 and no capture.
REQ-023 Async reset: pulse rst_n low between clock edges -> ex_valid=0 immediately.
